// File: rtl/or_gate_pkg.sv
// Shared constants for the or_gate logic-library primitive.
package or_gate_pkg;

  localparam int OR_GATE_CNT_W_DEFAULT = 8;

endpackage

// File: rtl/or_gate_hit_counter.sv
// Saturating up-counter: advances once per rising clk edge while inc is high,
// parks at all-ones, and clears asynchronously on rst_n low.
module or_gate_hit_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/or_gate.sv
// Bitwise OR gate with a registered copy of the result and a saturating
// count of clock edges at which any output bit was high.
module or_gate
  import or_gate_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = OR_GATE_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             any,
  output logic [CNT_W-1:0] hit_cnt
);

  // The gate itself never depends on clk/rst_n, so it works with both tied off.
  assign out = a | b;
  assign any = |out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out;
    end
  end

  or_gate_hit_counter #(
    .CNT_W(CNT_W)
  ) u_hit_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (any),
    .count(hit_cnt)
  );

endmodule

// File: tb/tb_or_gate.sv
// Bench for or_gate: a 1-bit instance, a 1-bit instance with a 3-bit counter,
// and an 8-bit instance, all sharing clk and rst_n.
module tb_or_gate;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       a, b;
  logic [7:0] a8, b8;

  logic       out1, out_q1, any1;
  logic [7:0] hit_cnt1;
  logic       out_s, out_q_s, any_s;
  logic [2:0] hit_cnt_s;
  logic [7:0] out8, out_q8;
  logic       any8;
  logic [7:0] hit_cnt8;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  or_gate #(.WIDTH(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .out(out1), .out_q(out_q1), .any(any1), .hit_cnt(hit_cnt1)
  );

  or_gate #(.WIDTH(1), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .out(out_s), .out_q(out_q_s), .any(any_s), .hit_cnt(hit_cnt_s)
  );

  or_gate #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8),
    .out(out8), .out_q(out_q8), .any(any8), .hit_cnt(hit_cnt8)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    a = 1'b0; b = 1'b0; a8 = '0; b8 = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clk_en = 1'b1;
    rst_n  = 1'b0;
    a = 1'b1; b = 1'b1; a8 = 8'hFF; b8 = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_q1 !== 1'b0 || hit_cnt1 !== 8'd0) begin
      errors++;
      $display("FAIL reset_dut1: out_q=%b hit_cnt=%0d, expected 0/0", out_q1, hit_cnt1);
    end
    checks++;
    if (out_q_s !== 1'b0 || hit_cnt_s !== 3'd0) begin
      errors++;
      $display("FAIL reset_sat: out_q=%b hit_cnt=%0d, expected 0/0", out_q_s, hit_cnt_s);
    end
    checks++;
    if (out_q8 !== 8'h00 || hit_cnt8 !== 8'd0) begin
      errors++;
      $display("FAIL reset_w8: out_q=%h hit_cnt=%0d, expected 00/0", out_q8, hit_cnt8);
    end
    a = 1'b0; b = 1'b0; a8 = '0; b8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] ab;
    clk_en = 1'b0;
    #7;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a = ab[1]; b = ab[0];
      #2;
      checks++;
      if (out1 !== (ab[1] | ab[0]) || any1 !== (ab[1] | ab[0])) begin
        errors++;
        $display("FAIL truth_table ab=%b: out=%b any=%b, expected %b", ab, out1, any1, ab[1] | ab[0]);
      end
    end
    a = 1'b0; b = 1'b0;
    #2;
    clk_en = 1'b1;
  endtask

  task automatic test_registered();
    do_reset();
    a = 1'b1; b = 1'b0;
    exp_q.push_back(8'd1);
    #1;
    checks++;
    if (out_q1 !== 1'b0) begin
      errors++;
      $display("FAIL reg_before_edge: out_q=%b, expected 0", out_q1);
    end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (out_q1 !== exp_v[0]) begin
      errors++;
      $display("FAIL reg_rise: out_q=%b, expected %b", out_q1, exp_v[0]);
    end
    @(negedge clk);
    a = 1'b0; b = 1'b0;
    exp_q.push_back(8'd0);
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (out_q1 !== exp_v[0]) begin
      errors++;
      $display("FAIL reg_fall: out_q=%b, expected %b", out_q1, exp_v[0]);
    end
  endtask

  task automatic test_counter();
    int model = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a = (i < 5); b = 1'b0;
      if (a) model = model + 1;
      exp_q.push_back(8'(model));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (hit_cnt1 !== exp_v) begin
        errors++;
        $display("FAIL counter edge %0d: hit_cnt=%0d, expected %0d", i, hit_cnt1, exp_v);
      end
      @(negedge clk);
    end
    a = 1'b0;
  endtask

  task automatic test_saturation();
    int model = 0;
    do_reset();
    a = 1'b1; b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (model < 7) model = model + 1;
      exp_q.push_back(8'(model));
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (hit_cnt_s !== exp_v[2:0]) begin
        errors++;
        $display("FAIL saturation edge %0d: hit_cnt=%0d, expected %0d", i, hit_cnt_s, exp_v[2:0]);
      end
      @(negedge clk);
    end
    checks++;
    if (hit_cnt1 !== 8'd10) begin
      errors++;
      $display("FAIL wide_count: hit_cnt=%0d, expected 10", hit_cnt1);
    end
    a = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    a = 1'b1; b = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (hit_cnt1 !== 8'd4 || out_q1 !== 1'b1) begin
      errors++;
      $display("FAIL async_precond: hit_cnt=%0d out_q=%b, expected 4/1", hit_cnt1, out_q1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (hit_cnt1 !== 8'd0 || out_q1 !== 1'b0) begin
      errors++;
      $display("FAIL async_clear: hit_cnt=%0d out_q=%b, expected 0/0", hit_cnt1, out_q1);
    end
    a = 1'b0; b = 1'b1;
    #1;
    checks++;
    if (out1 !== 1'b1 || any1 !== 1'b1) begin
      errors++;
      $display("FAIL out_in_reset: out=%b any=%b, expected 1/1", out1, any1);
    end
    @(posedge clk); #1;
    checks++;
    if (hit_cnt1 !== 8'd0 || out_q1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: hit_cnt=%0d out_q=%b, expected 0/0", hit_cnt1, out_q1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a = 1'b0; b = 1'b0;
  endtask

  task automatic test_width8();
    do_reset();
    a8 = 8'hA0; b8 = 8'h05;
    exp_q.push_back(8'hA5);
    #1;
    checks++;
    if (out8 !== 8'hA5 || any8 !== 1'b1) begin
      errors++;
      $display("FAIL w8_comb: out=%h any=%b, expected a5/1", out8, any8);
    end
    @(posedge clk); #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (out_q8 !== exp_v) begin
      errors++;
      $display("FAIL w8_reg: out_q=%h, expected %h", out_q8, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    int model = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = (i % 4 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if (i % 4 == 0) a8 = 8'h00;
      if ((a8 | b8) != 8'h00) model = model + 1;
      exp_q.push_back(a8 | b8);
      @(posedge clk); #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (out_q8 !== exp_v || hit_cnt8 !== 8'(model)) begin
        errors++;
        $display("FAIL b2b cycle %0d: out_q=%h hit_cnt=%0d, expected %h/%0d",
                 i, out_q8, hit_cnt8, exp_v, model);
      end
      @(negedge clk);
    end
    a8 = '0; b8 = '0;
  endtask

  initial begin
    clk_en = 1'b1;
    rst_n  = 1'b0;
    a = 1'b0; b = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_truth_table();
    test_registered();
    test_counter();
    test_saturation();
    test_async_reset();
    test_width8();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
